// File: rtl/key_conditioner.sv
// key_conditioner: push-button conditioner.
//   KEY -> two-flop synchronizer -> debouncer (LEVEL) -> event FSM producing
//   one-cycle PRESS / RELEASE / LONG / REPEAT pulses and a HELD level.
// Optional feature: define KEY_CONDITIONER_REPEAT_EN to enable the auto-repeat
// pulse while the key stays in the long-hold state; otherwise REPEAT is tied 0.
module key_conditioner #(
  parameter int DEB_CNT    = 500000,   // agreeing samples needed to accept a level change
  parameter int LONG_CNT   = 50000000, // cycles from PRESS to LONG
  parameter int REPEAT_CNT = 10000000  // cycles between REPEAT pulses
) (
  input  logic CK,
  input  logic RST_N,
  input  logic KEY,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic REPEAT,
  output logic HELD
);

  // Debounce counter only needs to reach DEB_CNT-1.
  localparam int                 DEB_W    = $clog2(DEB_CNT);
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CNT - 1);
  localparam logic [DEB_W-1:0]   DEB_ONE  = DEB_W'(1);

  // One hold counter serves both the LONG and the REPEAT terminal counts.
  localparam int                 HOLD_MAX  = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int                 HOLD_W    = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0]  LONG_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam logic [HOLD_W-1:0]  REP_LAST  = HOLD_W'(REPEAT_CNT - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HOLD = 2'd2
  } state_t;

  logic              key_meta;
  logic              ks;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_hit;
  logic              rise;
  logic              fall;

  state_t            state;
  state_t            state_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nx;
  logic              press_nx;
  logic              release_nx;
  logic              long_nx;
`ifdef KEY_CONDITIONER_REPEAT_EN
  logic              repeat_nx;
`endif

  // Two-flop synchronizer for the asynchronous button input.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would collapse the two stages into one.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      key_meta <= 1'b0;
      ks       <= 1'b0;
    end else begin
      key_meta <= KEY;
      ks       <= key_meta;
    end
  end

  // The cycle in which the debouncer accepts a new level; the FSM acts on
  // this same event so its pulses line up with the LEVEL change.
  assign deb_hit = (ks != LEVEL) && (deb_cnt == DEB_LAST);
  assign rise    = deb_hit && !LEVEL;
  assign fall    = deb_hit &&  LEVEL;

  // Debouncer: count disagreeing samples, toggle LEVEL after DEB_CNT of them.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      deb_cnt <= '0;
      LEVEL   <= 1'b0;
    end else if (ks == LEVEL) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      LEVEL   <= ~LEVEL;
    end else begin
      deb_cnt <= deb_cnt + DEB_ONE;
    end
  end

  // Next-state, hold-counter and pulse decode; release wins over any
  // terminal count that lands on the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_nx   = state;
    hold_nx    = hold_cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    long_nx    = 1'b0;
`ifdef KEY_CONDITIONER_REPEAT_EN
    repeat_nx  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESSED;
          press_nx = 1'b1;
          hold_nx  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
          hold_nx    = '0;
        end else if (hold_cnt == LONG_LAST) begin
          state_nx = LONG_HOLD;
          long_nx  = 1'b1;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_ONE;
        end
      end
      LONG_HOLD: begin
        if (fall) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
          hold_nx    = '0;
        end
`ifdef KEY_CONDITIONER_REPEAT_EN
        else if (hold_cnt == REP_LAST) begin
          repeat_nx = 1'b1;
          hold_nx   = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_ONE;
        end
`endif
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = '0;
      end
    endcase
  end

  // State register and registered pulse/level outputs.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      hold_cnt <= '0;
      PRESS    <= 1'b0;
      RELEASE  <= 1'b0;
      LONG     <= 1'b0;
      HELD     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      PRESS    <= press_nx;
      RELEASE  <= release_nx;
      LONG     <= long_nx;
      HELD     <= (state_nx == LONG_HOLD);
    end
  end

`ifdef KEY_CONDITIONER_REPEAT_EN
  // Auto-repeat pulse register.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      REPEAT <= 1'b0;
    end else begin
      REPEAT <= repeat_nx;
    end
  end
`else
  assign REPEAT = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed self-checking bench for key_conditioner with
// DEB_CNT=4, LONG_CNT=20, REPEAT_CNT=8. Edge numbers are counted from the
// first rising edge after KEY (or RST_N) is changed.
module tb_key_conditioner;

  logic CK;
  logic RST_N;
  logic KEY;
  logic LEVEL, PRESS, RELEASE, LONG, REPEAT, HELD;

  key_conditioner #(
    .DEB_CNT    (4),
    .LONG_CNT   (20),
    .REPEAT_CNT (8)
  ) dut (
    .CK      (CK),
    .RST_N   (RST_N),
    .KEY     (KEY),
    .LEVEL   (LEVEL),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .LONG    (LONG),
    .REPEAT  (REPEAT),
    .HELD    (HELD)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int vectors     = 0;
  int miscompares = 0;

  // Event log for the current window.
  int edge_n;
  int n_press, n_rel, n_long, n_rep, n_held, n_level, multi;
  int e_press, e_rel, e_long, e_rep, e_rep_last, e_held, e_level;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    edge_n  = 0;
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
    n_held  = 0; n_level = 0; multi = 0;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0; e_rep_last = 0;
    e_held  = 0; e_level = 0;
  endtask

  // Advance n rising edges, sampling outputs 1 time unit after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CK);
      #1;
      edge_n++;
      if (PRESS)   begin n_press++; if (e_press == 0) e_press = edge_n; end
      if (RELEASE) begin n_rel++;   if (e_rel   == 0) e_rel   = edge_n; end
      if (LONG)    begin n_long++;  if (e_long  == 0) e_long  = edge_n; end
      if (REPEAT)  begin n_rep++;   if (e_rep   == 0) e_rep   = edge_n; e_rep_last = edge_n; end
      if (HELD)    begin n_held++;  if (e_held  == 0) e_held  = edge_n; end
      if (LEVEL)   begin n_level++; if (e_level == 0) e_level = edge_n; end
      if (int'(PRESS) + int'(RELEASE) + int'(LONG) + int'(REPEAT) > 1) multi++;
    end
  endtask

  function automatic int outs();
    return int'({LEVEL, PRESS, RELEASE, LONG, REPEAT, HELD});
  endfunction

  initial begin
    RST_N = 1'b0;
    KEY   = 1'b0;
    clear_log();

    // Reset state
    #1;
    check("reset_outputs", outs(), 0);
    run(2);
    RST_N = 1'b1;
    run(5);
    check("idle_outputs", outs(), 0);

    // Long hold: PRESS/LEVEL at 6, LONG/HELD at 26
    clear_log();
    KEY = 1'b1;
    run(30);
    check("hold_press_edge",  e_press, 6);
    check("hold_press_count", n_press, 1);
    check("hold_level_edge",  e_level, 6);
    check("hold_long_edge",   e_long,  26);
    check("hold_held_edge",   e_held,  26);
    check("hold_no_release",  n_rel,   0);

    // Keep holding to edge 80: repeats at 34..74 when enabled
    run(50);
    check("hold_long_once",   n_long,  1);
    check("hold_held_cycles", n_held,  55);
`ifdef KEY_CONDITIONER_REPEAT_EN
    check("repeat_count", n_rep, 6);
    check("repeat_first", e_rep, 34);
    check("repeat_last",  e_rep_last, 74);
`else
    check("repeat_count", n_rep, 0);
`endif
    check("hold_exclusive", multi, 0);

    // Release from long hold: RELEASE 6 edges after KEY falls
    clear_log();
    KEY = 1'b0;
    run(12);
    check("lrel_release_edge", e_rel, 6);
    check("lrel_release_cnt",  n_rel, 1);
    check("lrel_held_cycles",  n_held, 5);
`ifdef KEY_CONDITIONER_REPEAT_EN
    check("lrel_repeat_cnt", n_rep, 1);
`else
    check("lrel_repeat_cnt", n_rep, 0);
`endif
    check("lrel_outputs", outs(), 0);

    // Short glitch: 3 cycles high is rejected
    clear_log();
    KEY = 1'b1;
    run(3);
    KEY = 1'b0;
    run(20);
    check("glitch_level", n_level, 0);
    check("glitch_press", n_press, 0);
    check("glitch_rel",   n_rel,   0);
    check("glitch_long",  n_long,  0);

    // Short press: release after 10 cycles of LEVEL=1
    clear_log();
    KEY = 1'b1;
    run(15);
    KEY = 1'b0;
    run(15);
    check("short_press_edge", e_press, 6);
    check("short_rel_edge",   e_rel,   21);
    check("short_level_cyc",  n_level, 15);
    check("short_no_long",    n_long,  0);
    check("short_no_held",    n_held,  0);

    // Reset mid-hold with KEY high
    clear_log();
    KEY = 1'b1;
    run(30);
    check("rst_pre_held", int'(HELD), 1);
    RST_N = 1'b0;
    #1;
    check("rst_async_outputs", outs(), 0);
    run(2);
    check("rst_held_outputs", outs(), 0);
    check("rst_no_release", n_rel, 0);
    RST_N = 1'b1;
    clear_log();
    run(30);
    check("rst_press_edge", e_press, 6);
    check("rst_no_release_after", n_rel, 0);
    check("rst_long_edge", e_long, 26);
    KEY = 1'b0;
    run(12);
    check("rst_final_outputs", outs(), 0);

    // Release lands on the LONG terminal-count edge (26)
    clear_log();
    KEY = 1'b1;
    run(20);
    KEY = 1'b0;
    run(15);
    check("tie_press_edge", e_press, 6);
    check("tie_rel_edge",   e_rel,   26);
    check("tie_no_long",    n_long,  0);
    check("tie_no_held",    n_held,  0);
    check("tie_exclusive",  multi,   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
